// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle between EX/MEM (master) and the SRAM responder (slave).
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        rdata_valid;
  logic        stallreq;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, rdata_valid, stallreq
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, rdata_valid, stallreq
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word memory with byte-lane writes, reads returned after
// LATENCY cycles, stall request raised while a read is outstanding.
module data_sram_resp #(
  parameter int ADDR_WD = 10,
  parameter int LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  data_sram_if.slave sram
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit       MULTI    = (LATENCY > 1);
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WD];

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [ADDR_WD-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               valid_q, valid_d;

  logic [ADDR_WD-1:0] idx;
  logic               accept, rd_acc, wr_acc;

  // Byte offset and high address bits alias away.
  assign idx = sram.data_sram_addr[ADDR_WD+1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sram.data_sram_addr[31:ADDR_WD+2], sram.data_sram_addr[1:0]};

  // Requests are only taken in IDLE and never while reset is asserted.
  assign accept = rst && sram.data_sram_en && (state_q == IDLE);
  assign rd_acc = accept && (sram.data_sram_wen == 4'b0000);
  assign wr_acc = accept && (sram.data_sram_wen != 4'b0000);

  // Byte-lane write at the acceptance edge; memory is not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.data_sram_wen[i]) mem[idx][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Next-state: read acceptance, wait-state countdown, data load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          rd_idx_d = idx;
          if (MULTI) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            rdata_d = mem[idx];
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // Counter steps 1 -> 0 on this edge: data lands with the valid pulse.
        if (cnt_q <= 2'd1) begin
          rdata_d = mem[rd_idx_q];
          valid_d = 1'b1;
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; rd_idx needs no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
    rd_idx_q <= rd_idx_d;
  end

  assign sram.data_sram_rdata = rdata_q;
  assign sram.rdata_valid     = valid_q;
  // Combinational so EX stalls in the acceptance cycle; reset kills it at once.
  assign sram.stallreq = rst && ((MULTI && rd_acc) || (state_q == WAIT));
endmodule
